// File: rtl/ser_pkg.sv
// ============================================================================
//  Module      : ser_pkg
//  Description : Shared types and constants for the bit_serializer block:
//                shifter state encoding, maximum word width and the parity
//                helper used by the optional parity stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ser_pkg;

    // Shifter states; S_PAR is only reachable when parity is compiled in
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } ser_state_t;

    localparam int SER_MAX_WIDTH = 32;

    // Even parity of a word zero-extended to the maximum width
    function automatic logic ser_even_parity(input logic [SER_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_hold_buf.sv
// ============================================================================
//  Module      : ser_hold_buf
//  Description : One-entry holding buffer in front of the shifter. Written on
//                an accepted handshake, read-and-cleared when the shifter
//                loads. Lets the next word wait while the current one shifts.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             hvalid,
    output logic [WIDTH-1:0] hbuf
);

    logic             hvalid_q, hvalid_d;
    logic [WIDTH-1:0] hbuf_q,   hbuf_d;

    // Next-state: a load empties the entry; an accept fills it. The two never
    // coincide because an accept needs the entry empty and a load needs it full.
    always_comb begin
        hvalid_d = hvalid_q;
        hbuf_d   = hbuf_q;
        if (rd_en) begin
            hvalid_d = 1'b0;
            hbuf_d   = '0;
        end
        if (wr_en) begin
            hvalid_d = 1'b1;
            hbuf_d   = wr_data;
        end
    end

    // Buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hvalid_q <= 1'b0;
            hbuf_q   <= '0;
        end else begin
            hvalid_q <= hvalid_d;
            hbuf_q   <= hbuf_d;
        end
    end

    assign hvalid = hvalid_q;
    assign hbuf   = hbuf_q;

endmodule

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
//  Module      : bit_serializer
//  Description : Parallel-to-serial front end for the 1101 sequence
//                detectors. Accepts WIDTH-bit words (2..32) over valid/ready
//                and shifts them out one bit per clock on x, MSB or LSB first.
//                A one-entry holding buffer allows gapless back-to-back words.
//                Optional feature macro: SER_PARITY_EN appends one even-parity
//                bit after each word's data bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             x_q,         x_d;
    logic             x_valid_q,   x_valid_d;
    logic             word_done_q, word_done_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             hvalid;
    logic [WIDTH-1:0] hbuf;
    logic             accept;
    logic             load;
    logic             last_bit;

    assign din_ready = !hvalid && !reset;
    assign accept    = din_valid && din_ready;
    assign last_bit  = (cnt_q == CNT_LAST);

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (din),
        .rd_en   (load),
        .hvalid  (hvalid),
        .hbuf    (hbuf)
    );

    // Shifter FSM next-state; a reload on the last bit keeps words gapless
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hvalid) begin
                    load = 1'b1;
                end
            end
            S_DATA: begin
                if (!last_bit) begin
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
`ifdef SER_PARITY_EN
                    state_d = S_PAR;
`else
                    if (hvalid) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
                if (hvalid) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d = S_DATA;
            shreg_d = hbuf;
            cnt_d   = '0;
`ifdef SER_PARITY_EN
            par_d   = ser_even_parity(SER_MAX_WIDTH'(hbuf));
`endif
        end
    end

    // Output decode from the next state so x/x_valid/word_done are registered
    always_comb begin
        x_d         = 1'b0;
        x_valid_d   = 1'b0;
        word_done_d = 1'b0;
        case (state_d)
            S_DATA: begin
                x_d       = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
                x_valid_d = 1'b1;
`ifndef SER_PARITY_EN
                word_done_d = (cnt_d == CNT_LAST);
`endif
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
                x_d         = par_d;
                x_valid_d   = 1'b1;
                word_done_d = 1'b1;
            end
`endif
            default: begin
                x_d         = 1'b0;
                x_valid_d   = 1'b0;
                word_done_d = 1'b0;
            end
        endcase
    end

    // State, shifter, counter and output registers; reset discards any word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign word_done = word_done_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Self-checking bench for bit_serializer. Two 4-bit instances
//                (MSB-first and LSB-first) share one handshake stream. A
//                schedule-based reference model predicts, per accepted word,
//                the load edge and the cycles occupied by its bits, and
//                compares every cycle. Directed cases also check fixed
//                bit patterns. Honours SER_PARITY_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bit_serializer;

    localparam int W    = 4;
`ifdef SER_PARITY_EN
    localparam int P    = W + 1;
    localparam logic [31:0] T1_A  = 32'b11011,       T1_B  = 32'b10111,       T1_WD = 32'b00001;
    localparam logic [31:0] T2_A  = 32'b0011001111,  T2_B  = 32'b1100011101,  T2_WD = 32'b0000100001;
    localparam logic [31:0] T3_A  = 32'b1011110010,  T3_B  = 32'b1101110010,  T3_WD = 32'b0000100001;
`else
    localparam int P    = W;
    localparam logic [31:0] T1_A  = 32'b1101,        T1_B  = 32'b1011,        T1_WD = 32'b0001;
    localparam logic [31:0] T2_A  = 32'b00110111,    T2_B  = 32'b11001110,    T2_WD = 32'b00010001;
    localparam logic [31:0] T3_A  = 32'b10111001,    T3_B  = 32'b11011001,    T3_WD = 32'b00010001;
`endif
    localparam int MAXC = 4096;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic [W-1:0] din       = '0;
    logic         din_valid = 1'b0;
    logic         rdy_m, x_m, xv_m, wd_m;
    logic         rdy_l, x_l, xv_l, wd_l;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .x(x_m), .x_valid(xv_m), .word_done(wd_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .word_done(wd_l)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference schedule: expected x / x_valid / word_done per cycle, per DUT
    bit   ex  [2][MAXC];
    bit   ev  [2][MAXC];
    bit   ewd [2][MAXC];
    // Observed history for directed pattern checks
    logic hx  [2][MAXC];
    logic hv  [2][MAXC];
    logic hwd [2][MAXC];

    int free_edge = 1;   // earliest edge at which the shifter can load
    int hv_end    = 0;   // holding buffer is full in cycles before this index
    bit acc_last  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    // Word accepted at edge e: it loads at the later of e+1 and the end of
    // the word in flight, then occupies P consecutive cycles.
    task automatic model_accept(input int e, input logic [W-1:0] w);
        int  ld;
        bit  b;
        ld = (e + 1 > free_edge) ? e + 1 : free_edge;
        for (int i = 0; i < P; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (i == W)      b = ^w;
                else if (d == 0) b = w[W-1-i];
                else             b = w[i];
                if (ld + i < MAXC) begin
                    ex[d][ld+i]  = b;
                    ev[d][ld+i]  = 1'b1;
                    ewd[d][ld+i] = (i == P - 1);
                end
            end
        end
        free_edge = ld + P;
        hv_end    = ld;
    endtask

    task automatic model_reset(input int e);
        for (int c = e; c < MAXC; c++) begin
            for (int d = 0; d < 2; d++) begin
                ex[d][c]  = 1'b0;
                ev[d][c]  = 1'b0;
                ewd[d][c] = 1'b0;
            end
        end
        free_edge = e + 1;
        hv_end    = e;
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge
    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        logic want_rdy;
        reset     = r;
        din_valid = v;
        din       = d;
        @(posedge clk);
        cyc++;
        acc_last = 1'b0;
        if (r) begin
            model_reset(cyc);
        end else if (v && (cyc - 1 >= hv_end)) begin
            model_accept(cyc, d);
            acc_last = 1'b1;
        end
        @(negedge clk);
        want_rdy = !r && (cyc >= hv_end);
        check("msb_ready", 32'(rdy_m), 32'(want_rdy));
        check("lsb_ready", 32'(rdy_l), 32'(want_rdy));
        check("msb_x",     32'(x_m),   32'(ex[0][cyc]));
        check("msb_xv",    32'(xv_m),  32'(ev[0][cyc]));
        check("msb_wd",    32'(wd_m),  32'(ewd[0][cyc]));
        check("lsb_x",     32'(x_l),   32'(ex[1][cyc]));
        check("lsb_xv",    32'(xv_l),  32'(ev[1][cyc]));
        check("lsb_wd",    32'(wd_l),  32'(ewd[1][cyc]));
        hx[0][cyc] = x_m;  hv[0][cyc] = xv_m;  hwd[0][cyc] = wd_m;
        hx[1][cyc] = x_l;  hv[1][cyc] = xv_l;  hwd[1][cyc] = wd_l;
    endtask

    // Concatenate observed valid bits in [from, to], first bit most significant
    task automatic collect(input int d, input int from, input int to,
                           output logic [31:0] xs, output logic [31:0] wds, output int n);
        xs = '0; wds = '0; n = 0;
        for (int c = from; c <= to; c++) begin
            if (hv[d][c] === 1'b1) begin
                xs  = {xs[30:0],  hx[d][c]};
                wds = {wds[30:0], hwd[d][c]};
                n++;
            end
        end
    endtask

    // Two words back to back with din_valid held through the backpressure
    task automatic pair(input logic [W-1:0] a, input logic [W-1:0] b);
        step(1'b0, 1'b1, a);
        for (int k = 0; k < 3 * P; k++) begin
            step(1'b0, 1'b1, b);
            if (acc_last) break;
        end
        repeat (2 * P + 3) step(1'b0, 1'b0, '0);
    endtask

    logic [31:0]  xs, wds;
    int           n, s0;
    logic         rr, cv, prev_r;
    logic [W-1:0] cd;

    initial begin
        repeat (3) step(1'b1, 1'b0, '0);

        // Single word 1101 from idle; first bit appears two edges after accept
        s0 = cyc + 1;
        step(1'b0, 1'b1, 4'b1101);
        repeat (P + 4) step(1'b0, 1'b0, '0);
        check("t1_lat_idle", 32'(hv[0][s0]),     32'd0);
        check("t1_lat_first", 32'(hv[0][s0+1]),  32'd1);
        collect(0, s0, cyc, xs, wds, n);
        check("t1_msb_n", n, P);  check("t1_msb_x", xs, T1_A);  check("t1_msb_wd", wds, T1_WD);
        collect(1, s0, cyc, xs, wds, n);
        check("t1_lsb_x", xs, T1_B);  check("t1_lsb_wd", wds, T1_WD);

        // Back-to-back 0011 then 0111, no gap between the words
        s0 = cyc + 1;
        pair(4'b0011, 4'b0111);
        collect(0, s0, cyc, xs, wds, n);
        check("t2_msb_n", n, 2 * P);  check("t2_msb_x", xs, T2_A);  check("t2_msb_wd", wds, T2_WD);
        collect(1, s0, cyc, xs, wds, n);
        check("t2_lsb_x", xs, T2_B);  check("t2_lsb_wd", wds, T2_WD);

        // 1011 then 1001: LSB-first pattern and a zero parity bit
        s0 = cyc + 1;
        pair(4'b1011, 4'b1001);
        collect(0, s0, cyc, xs, wds, n);
        check("t3_msb_x", xs, T3_A);  check("t3_msb_wd", wds, T3_WD);
        collect(1, s0, cyc, xs, wds, n);
        check("t3_lsb_n", n, 2 * P);  check("t3_lsb_x", xs, T3_B);

        // Reset during the second bit with another word buffered
        s0 = cyc + 1;
        step(1'b0, 1'b1, 4'b1010);
        step(1'b0, 1'b1, 4'b0110);
        step(1'b0, 1'b1, 4'b0110);
        step(1'b1, 1'b0, '0);
        check("t4_rst_xv", 32'(xv_m), 32'd0);
        step(1'b0, 1'b0, '0);
        check("t4_rdy_after", 32'(rdy_m), 32'd1);
        repeat (2 * P + 3) step(1'b0, 1'b0, '0);
        collect(0, s0, cyc, xs, wds, n);
        check("t4_msb_n", n, 2);  check("t4_msb_x", xs, 32'b10);  check("t4_msb_wd", wds, 32'd0);
        collect(1, s0, cyc, xs, wds, n);
        check("t4_lsb_n", n, 2);  check("t4_lsb_x", xs, 32'b01);

        // Random traffic with held-valid backpressure and occasional resets
        cv = 1'b0; cd = '0; prev_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            rr = ($urandom_range(0, 149) == 0);
            if (!(cv && !acc_last && !prev_r)) begin
                cv = ($urandom_range(0, 3) != 0);
                cd = W'($urandom);
            end
            step(rr, cv, cd);
            prev_r = rr;
        end
        repeat (2 * P + 2) step(1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
